// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port logic.
//   arb_state_t : arbiter FSM states (IDLE / BUSY_I / BUSY_D)
//   arb_grant_t : arbitration result (GNT_NONE / GNT_I / GNT_D)
//   MEM_DATA_W / MEM_MASK_W : memory data and byte-enable widths
//   INSTR_NOP   : instruction the fetch stage injects on flush
package cpu_mem_pkg;

    localparam int MEM_DATA_W = 64;
    localparam int MEM_MASK_W = 8;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } arb_grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Arbitration priority for the shared memory port.
//   clk, reset    : clock, synchronous active-high reset
//   instr_req     : fetch request, already masked by the caller
//   data_req      : load/store request, already masked by the caller
//   instr_level   : raw fetch request level (drives streak counting)
//   grant_strobe  : a grant is actually being issued this cycle
//   grant         : combinational arbitration result
// Data normally wins, but after MAX_DATA_STREAK consecutive data grants
// with fetch waiting, fetch is forced through.
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_req,
    input  logic       data_req,
    input  logic       instr_level,
    input  logic       grant_strobe,
    output arb_grant_t grant
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_reg;

    always_comb begin
        grant = GNT_NONE;
        if (data_req && (streak_reg < STREAK_MAX)) begin
            grant = GNT_D;
        end else if (instr_req) begin
            grant = GNT_I;
        end else if (data_req) begin
            grant = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_reg <= '0;
        end else if (grant_strobe) begin
            if ((grant == GNT_D) && instr_level) begin
                if (streak_reg != STREAK_MAX) begin
                    streak_reg <= streak_reg + 4'd1;
                end
            end else begin
                streak_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store.
// One transaction outstanding at a time; each requester receives its read
// data with a one-cycle valid pulse.
//   clk, reset              : clock, synchronous active-high reset
//   flush_in                : squash pending / in-flight fetch result
//   instr_read_in/_address  : fetch request (level) and address
//   data_read_in/_write_in  : load / store request (level)
//   data_address/_write_*   : data address, store data, byte enables
//   mem_ready_in/read_value : memory completion strobe and read data
//   mem_*_out               : registered memory transaction
//   instr_/data_read_value  : returned read data registers
//   instr_/data_valid_out   : completion pulses
//   instr_/data_stall_out   : requester waiting (combinational)
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_in,
    input  logic                  instr_read_in,
    input  logic [ADDR_W-1:0]     instr_address_in,
    input  logic                  data_read_in,
    input  logic                  data_write_in,
    input  logic [ADDR_W-1:0]     data_address_in,
    input  logic [MEM_DATA_W-1:0] data_write_value_in,
    input  logic [MEM_MASK_W-1:0] data_write_mask_in,
    input  logic                  mem_ready_in,
    input  logic [MEM_DATA_W-1:0] mem_read_value_in,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [ADDR_W-1:0]     mem_address_out,
    output logic [MEM_DATA_W-1:0] mem_write_value_out,
    output logic [MEM_MASK_W-1:0] mem_write_mask_out,
    output logic [MEM_DATA_W-1:0] instr_read_value_out,
    output logic                  instr_valid_out,
    output logic [MEM_DATA_W-1:0] data_read_value_out,
    output logic                  data_valid_out,
    output logic                  instr_stall_out,
    output logic                  data_stall_out
);

    arb_state_t state_reg;
    logic       squash_reg;
    logic       instr_req;
    logic       data_req;
    logic       grant_strobe;
    arb_grant_t grant;

    // A requester that sees its valid pulse this cycle drops its request
    // next cycle, so it must not win arbitration now.
    assign instr_req = instr_read_in & ~instr_valid_out;
    assign data_req  = (data_read_in | data_write_in) & ~data_valid_out;

    // A fetch grant coinciding with flush is cancelled outright.
    assign grant_strobe = (state_reg == IDLE) &&
                          ((grant == GNT_D) || ((grant == GNT_I) && !flush_in));

    assign instr_stall_out = instr_read_in & ~instr_valid_out;
    assign data_stall_out  = (data_read_in | data_write_in) & ~data_valid_out;

    mem_arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .instr_req   (instr_req),
        .data_req    (data_req),
        .instr_level (instr_read_in),
        .grant_strobe(grant_strobe),
        .grant       (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= IDLE;
            squash_reg           <= 1'b0;
            mem_req_out          <= 1'b0;
            mem_we_out           <= 1'b0;
            mem_address_out      <= '0;
            mem_write_value_out  <= '0;
            mem_write_mask_out   <= '0;
            instr_read_value_out <= '0;
            instr_valid_out      <= 1'b0;
            data_read_value_out  <= '0;
            data_valid_out       <= 1'b0;
        end else begin
            instr_valid_out <= 1'b0;
            data_valid_out  <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (grant_strobe && (grant == GNT_D)) begin
                        state_reg           <= BUSY_D;
                        mem_req_out         <= 1'b1;
                        mem_we_out          <= data_write_in;
                        mem_address_out     <= data_address_in;
                        mem_write_value_out <= data_write_value_in;
                        mem_write_mask_out  <= data_write_in ? data_write_mask_in : '0;
                    end else if (grant_strobe && (grant == GNT_I)) begin
                        state_reg           <= BUSY_I;
                        mem_req_out         <= 1'b1;
                        mem_we_out          <= 1'b0;
                        mem_address_out     <= instr_address_in;
                        mem_write_value_out <= '0;
                        mem_write_mask_out  <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ready_in) begin
                        state_reg          <= IDLE;
                        mem_req_out        <= 1'b0;
                        mem_we_out         <= 1'b0;
                        mem_write_mask_out <= '0;
                        squash_reg         <= 1'b0;
                        // Flush on the completion cycle also squashes.
                        if (!(squash_reg || flush_in)) begin
                            instr_read_value_out <= mem_read_value_in;
                            instr_valid_out      <= 1'b1;
                        end
                    end else if (flush_in) begin
                        squash_reg <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready_in) begin
                        state_reg          <= IDLE;
                        mem_req_out        <= 1'b0;
                        mem_we_out         <= 1'b0;
                        mem_write_mask_out <= '0;
                        data_valid_out     <= 1'b1;
                        if (!mem_we_out) begin
                            data_read_value_out <= mem_read_value_in;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset, flush_in, instr_read_in, data_read_in, data_write_in, mem_ready_in;
    logic [63:0] instr_address_in, data_address_in, data_write_value_in, mem_read_value_in;
    logic [7:0]  data_write_mask_in;
    logic        mem_req_out, mem_we_out, instr_valid_out, data_valid_out;
    logic        instr_stall_out, data_stall_out;
    logic [63:0] mem_address_out, mem_write_value_out, instr_read_value_out, data_read_value_out;
    logic [7:0]  mem_write_mask_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX), .ADDR_W(64)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush_in            (flush_in),
        .instr_read_in       (instr_read_in),
        .instr_address_in    (instr_address_in),
        .data_read_in        (data_read_in),
        .data_write_in       (data_write_in),
        .data_address_in     (data_address_in),
        .data_write_value_in (data_write_value_in),
        .data_write_mask_in  (data_write_mask_in),
        .mem_ready_in        (mem_ready_in),
        .mem_read_value_in   (mem_read_value_in),
        .mem_req_out         (mem_req_out),
        .mem_we_out          (mem_we_out),
        .mem_address_out     (mem_address_out),
        .mem_write_value_out (mem_write_value_out),
        .mem_write_mask_out  (mem_write_mask_out),
        .instr_read_value_out(instr_read_value_out),
        .instr_valid_out     (instr_valid_out),
        .data_read_value_out (data_read_value_out),
        .data_valid_out      (data_valid_out),
        .instr_stall_out     (instr_stall_out),
        .data_stall_out      (data_stall_out)
    );

    // Reference arbitration: 0 none, 1 fetch, 2 data.
    function automatic int predict(input logic ip, input logic dp, input int s);
        if (dp && s < MAX) return 2;
        if (ip) return 1;
        if (dp) return 2;
        return 0;
    endfunction

    function automatic int streak_after(input int g, input logic ilvl, input int s);
        if (g == 0) return s;
        if (g == 2 && ilvl) return (s + 1 > MAX) ? MAX : s + 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_in = 0; instr_read_in = 0; data_read_in = 0; data_write_in = 0; mem_ready_in = 0;
        instr_address_in = '0; data_address_in = '0; data_write_value_in = '0;
        data_write_mask_in = '0; mem_read_value_in = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; tick();
        n_checks++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req_out); end
        n_checks++; if ({instr_valid_out, data_valid_out} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {instr_valid_out, data_valid_out}); end
        n_checks++; if (instr_read_value_out !== 64'h0 || data_read_value_out !== 64'h0) begin n_fail++; $display("FAIL reset_values: got %h/%h want 0/0", instr_read_value_out, data_read_value_out); end
        n_checks++; if ({mem_we_out, mem_write_mask_out, mem_address_out} !== '0) begin n_fail++; $display("FAIL reset_mem: we %b mask %h addr %h want 0", mem_we_out, mem_write_mask_out, mem_address_out); end
        reset = 0;
        $display("reset: outputs checked");
    endtask

    task automatic test_single_fetch();
        do_reset();
        instr_read_in = 1; instr_address_in = 64'h1000;
        tick();
        n_checks++; if (mem_req_out !== 1'b1 || mem_address_out !== 64'h1000 || mem_we_out !== 1'b0) begin n_fail++; $display("FAIL fetch_issue: req %b addr %h we %b want 1 1000 0", mem_req_out, mem_address_out, mem_we_out); end
        n_checks++; if (instr_stall_out !== 1'b1) begin n_fail++; $display("FAIL fetch_stall: got %b want 1", instr_stall_out); end
        tick();
        n_checks++; if (instr_valid_out !== 1'b0 || mem_req_out !== 1'b1) begin n_fail++; $display("FAIL fetch_early: valid %b req %b want 0 1", instr_valid_out, mem_req_out); end
        mem_ready_in = 1; mem_read_value_in = 64'hDEADBEEF_00000013;
        tick();
        mem_ready_in = 0;
        n_checks++; if (instr_valid_out !== 1'b1 || instr_read_value_out !== 64'hDEADBEEF_00000013) begin n_fail++; $display("FAIL fetch_done: valid %b value %h want 1 deadbeef00000013", instr_valid_out, instr_read_value_out); end
        n_checks++; if (instr_stall_out !== 1'b0 || mem_req_out !== 1'b0) begin n_fail++; $display("FAIL fetch_release: stall %b req %b want 0 0", instr_stall_out, mem_req_out); end
        instr_read_in = 0;
        tick();
        n_checks++; if (instr_valid_out !== 1'b0 || mem_req_out !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: valid %b req %b want 0 0", instr_valid_out, mem_req_out); end
        $display("fetch 0x1000 -> %h", instr_read_value_out);
    endtask

    task automatic test_store();
        do_reset();
        data_read_in = 1; data_address_in = 64'h3000;
        tick();
        n_checks++; if (mem_req_out !== 1'b1 || mem_we_out !== 1'b0 || mem_write_mask_out !== 8'h00) begin n_fail++; $display("FAIL load_issue: req %b we %b mask %h want 1 0 00", mem_req_out, mem_we_out, mem_write_mask_out); end
        mem_ready_in = 1; mem_read_value_in = 64'hCAFE;
        tick();
        mem_ready_in = 0;
        n_checks++; if (data_valid_out !== 1'b1 || data_read_value_out !== 64'hCAFE) begin n_fail++; $display("FAIL load_min_latency: valid %b value %h want 1 cafe", data_valid_out, data_read_value_out); end
        data_read_in = 0;
        data_write_in = 1; data_address_in = 64'h2008; data_write_mask_in = 8'h0F; data_write_value_in = 64'h55;
        tick();
        n_checks++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL no_duplicate: req %b want 0", mem_req_out); end
        tick();
        flush_in = 1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (mem_req_out !== 1'b1 || mem_we_out !== 1'b1 || mem_write_mask_out !== 8'h0F ||
                mem_address_out !== 64'h2008 || mem_write_value_out !== 64'h55) begin
                n_fail++; $display("FAIL store_hold[%0d]: req %b we %b mask %h addr %h val %h", k, mem_req_out, mem_we_out, mem_write_mask_out, mem_address_out, mem_write_value_out);
            end
            if (k < 2) tick();
        end
        flush_in = 0; mem_ready_in = 1; mem_read_value_in = 64'h1234;
        tick();
        mem_ready_in = 0;
        n_checks++; if (data_valid_out !== 1'b1 || data_read_value_out !== 64'hCAFE) begin n_fail++; $display("FAIL store_done: valid %b value %h want 1 cafe", data_valid_out, data_read_value_out); end
        data_write_in = 0;
        tick();
        n_checks++; if (data_valid_out !== 1'b0 || mem_req_out !== 1'b0) begin n_fail++; $display("FAIL store_pulse: valid %b req %b want 0 0", data_valid_out, mem_req_out); end
        $display("store 0x2008 mask 0f done");
    endtask

    task automatic test_contention();
        int s = 0, g;
        logic vi = 0, vd = 0;
        do_reset();
        instr_read_in = 1; instr_address_in = 64'h100;
        data_read_in = 1; data_address_in = 64'h200;
        for (int k = 0; k < 10; k++) begin
            g = predict(~vi, ~vd, s);
            s = streak_after(g, 1'b1, s);
            tick();
            vi = 0; vd = 0;
            n_checks++; if (mem_req_out !== 1'b1 || mem_address_out !== ((g == 1) ? 64'h100 : 64'h200)) begin n_fail++; $display("FAIL contend_grant[%0d]: req %b addr %h want grant %0d", k, mem_req_out, mem_address_out, g); end
            n_checks++; if (instr_stall_out !== 1'b1) begin n_fail++; $display("FAIL contend_stall[%0d]: got %b want 1", k, instr_stall_out); end
            mem_ready_in = 1; mem_read_value_in = 64'(k);
            tick();
            mem_ready_in = 0;
            n_checks++; if (((g == 1) ? instr_valid_out : data_valid_out) !== 1'b1) begin n_fail++; $display("FAIL contend_valid[%0d]: ivalid %b dvalid %b grant %0d", k, instr_valid_out, data_valid_out, g); end
            if (g == 1) vi = 1; else vd = 1;
            $display("contention grant %0d: %s", k, (g == 1) ? "I" : "D");
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        instr_read_in = 1; instr_address_in = 64'h1000;
        tick(); tick();
        flush_in = 1; tick(); flush_in = 0;
        tick();
        mem_ready_in = 1; mem_read_value_in = 64'hBAD;
        tick();
        mem_ready_in = 0;
        n_checks++; if (instr_valid_out !== 1'b0 || instr_read_value_out !== 64'h0 || mem_req_out !== 1'b0) begin n_fail++; $display("FAIL flush_busy: valid %b value %h req %b want 0 0 0", instr_valid_out, instr_read_value_out, mem_req_out); end
        instr_address_in = 64'h1004;
        tick();
        n_checks++; if (mem_req_out !== 1'b1 || mem_address_out !== 64'h1004) begin n_fail++; $display("FAIL refetch_issue: req %b addr %h want 1 1004", mem_req_out, mem_address_out); end
        mem_ready_in = 1; mem_read_value_in = 64'h0000_0013_0000_0093;
        tick();
        mem_ready_in = 0;
        n_checks++; if (instr_valid_out !== 1'b1 || instr_read_value_out !== 64'h0000_0013_0000_0093) begin n_fail++; $display("FAIL refetch_done: valid %b value %h", instr_valid_out, instr_read_value_out); end
        instr_address_in = 64'h1008;
        tick(); tick();
        mem_ready_in = 1; flush_in = 1; mem_read_value_in = 64'hBAD2;
        tick();
        mem_ready_in = 0; flush_in = 0;
        n_checks++; if (instr_valid_out !== 1'b0 || instr_read_value_out !== 64'h0000_0013_0000_0093) begin n_fail++; $display("FAIL flush_on_ready: valid %b value %h want 0 old", instr_valid_out, instr_read_value_out); end
        flush_in = 1;
        tick();
        flush_in = 0;
        n_checks++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL flush_idle_cancel: req %b want 0", mem_req_out); end
        tick();
        n_checks++; if (mem_req_out !== 1'b1 || mem_address_out !== 64'h1008) begin n_fail++; $display("FAIL after_cancel: req %b addr %h want 1 1008", mem_req_out, mem_address_out); end
        mem_ready_in = 1; mem_read_value_in = 64'h77;
        tick();
        mem_ready_in = 0; instr_read_in = 0;
        n_checks++; if (instr_valid_out !== 1'b1 || instr_read_value_out !== 64'h77) begin n_fail++; $display("FAIL after_cancel_done: valid %b value %h", instr_valid_out, instr_read_value_out); end
        tick();
        $display("flush scenarios done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_read_in = 1; data_address_in = 64'h4000;
        tick(); tick();
        reset = 1; tick(); reset = 0; data_read_in = 0;
        n_checks++; if (mem_req_out !== 1'b0 || mem_we_out !== 1'b0 || instr_valid_out !== 1'b0 || data_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid: req %b we %b iv %b dv %b want 0", mem_req_out, mem_we_out, instr_valid_out, data_valid_out); end
        mem_ready_in = 1; mem_read_value_in = 64'hF00D;
        tick();
        mem_ready_in = 0;
        n_checks++; if (data_valid_out !== 1'b0 || instr_valid_out !== 1'b0 || data_read_value_out !== 64'h0) begin n_fail++; $display("FAIL stray_ready: dv %b iv %b value %h want 0", data_valid_out, instr_valid_out, data_read_value_out); end
        instr_read_in = 1; instr_address_in = 64'h500; data_read_in = 1; data_address_in = 64'h600;
        tick();
        n_checks++; if (mem_address_out !== 64'h600) begin n_fail++; $display("FAIL post_reset_grant: addr %h want 600", mem_address_out); end
        $display("reset mid-transaction done");
    endtask

    task automatic test_random(input int n);
        logic ip = 0, dp = 0, dwr = 0, vi = 0, vd = 0;
        logic [63:0] ia = 0, da = 0, dv = 0, rd, exp_iv = 0, exp_dv = 0;
        logic [7:0] dm = 0;
        int s = 0, g, lat, served = 0, guard = 0;
        do_reset();
        while (served < n && guard < 3000) begin
            guard++;
            if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = {$urandom, $urandom}; end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dwr = 1'($urandom_range(0, 1)); da = {$urandom, $urandom};
                dv = {$urandom, $urandom}; dm = 8'($urandom);
            end
            instr_read_in = ip; instr_address_in = ia;
            data_read_in = dp & ~dwr; data_write_in = dp & dwr;
            data_address_in = da; data_write_value_in = dv; data_write_mask_in = dm;
            g = predict(ip & ~vi, dp & ~vd, s);
            s = streak_after(g, ip, s);
            tick();
            vi = 0; vd = 0;
            if (g == 0) begin
                n_checks++; if (mem_req_out !== 1'b0) begin n_fail++; $display("FAIL rnd_idle: req %b want 0", mem_req_out); end
                continue;
            end
            n_checks++;
            if (mem_req_out !== 1'b1 || mem_address_out !== ((g == 1) ? ia : da) ||
                mem_we_out !== ((g == 2) && dwr) || mem_write_mask_out !== (((g == 2) && dwr) ? dm : 8'h00) ||
                (g == 2 && dwr && mem_write_value_out !== dv)) begin
                n_fail++; $display("FAIL rnd_issue: grant %0d req %b addr %h we %b mask %h", g, mem_req_out, mem_address_out, mem_we_out, mem_write_mask_out);
            end
            n_checks++; if (instr_stall_out !== ip || data_stall_out !== dp) begin n_fail++; $display("FAIL rnd_stall: %b%b want %b%b", instr_stall_out, data_stall_out, ip, dp); end
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                tick();
                n_checks++; if (mem_req_out !== 1'b1 || mem_address_out !== ((g == 1) ? ia : da)) begin n_fail++; $display("FAIL rnd_hold: req %b addr %h", mem_req_out, mem_address_out); end
            end
            rd = {$urandom, $urandom};
            mem_ready_in = 1; mem_read_value_in = rd;
            tick();
            mem_ready_in = 0;
            if (g == 1) begin
                exp_iv = rd;
                n_checks++; if (instr_valid_out !== 1'b1 || data_valid_out !== 1'b0 || instr_read_value_out !== exp_iv || data_read_value_out !== exp_dv) begin n_fail++; $display("FAIL rnd_fetch_done: iv %b dv %b ival %h", instr_valid_out, data_valid_out, instr_read_value_out); end
                vi = 1; ip = 0;
            end else begin
                if (!dwr) exp_dv = rd;
                n_checks++; if (data_valid_out !== 1'b1 || instr_valid_out !== 1'b0 || data_read_value_out !== exp_dv || instr_read_value_out !== exp_iv) begin n_fail++; $display("FAIL rnd_data_done: dv %b iv %b dval %h", data_valid_out, instr_valid_out, data_read_value_out); end
                vd = 1; dp = 0;
            end
            served++;
            $display("rnd txn %0d: %s addr %h lat %0d", served, (g == 1) ? "fetch" : (dwr ? "store" : "load"), (g == 1) ? ia : da, lat + 1);
        end
        n_checks++; if (served != n) begin n_fail++; $display("FAIL rnd_budget: served %0d want %0d", served, n); end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_flush();
        test_reset_mid();
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
